// File: rtl/gen_chain_seq.sv
`timescale 1ns/1ps
// WOTS chain sequencer: walks chain steps [start_step, end_step) through
// the hash core, feeding each digest back as the next message.
module gen_chain_seq #(
   parameter int WOTS_W     = 16,
   parameter int WOTS_LOG_W = $clog2(WOTS_W),
   parameter int N          = 256
) (
   input  logic                  io_mainClk,
   input  logic                  io_systemReset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WOTS_LOG_W-1:0] start_step,
   input  logic [WOTS_LOG_W-1:0] end_step,
   input  logic [N-1:0]          chain_in,
   output logic                  hash_start,
   output logic [WOTS_LOG_W-1:0] hash_step,
   output logic [N-1:0]          hash_msg,
   input  logic                  hash_done,
   input  logic [N-1:0]          hash_digest,
   output logic [N-1:0]          chain_out,
   output logic [WOTS_LOG_W-1:0] iter_cnt,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FIN
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [N-1:0]          chain_reg;
   logic [WOTS_LOG_W-1:0] step_reg;
   logic [WOTS_LOG_W-1:0] end_reg;
   logic [WOTS_LOG_W-1:0] iter_reg;
   logic [WOTS_LOG_W-1:0] step_inc;
   logic                  accept;
   logic                  advance;
   logic                  last_step;

   assign step_inc  = step_reg + 1'b1;
   assign last_step = (step_inc == end_reg);
   assign accept    = (state == S_IDLE) && start && !abort;
   assign advance   = (state == S_WAIT) && hash_done && !abort;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start)
               state_nxt = (end_step > start_step) ? S_ISSUE : S_FIN;
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (hash_done)
               state_nxt = last_step ? S_FIN : S_ISSUE;
         end
         S_FIN: state_nxt = S_IDLE;
      endcase
      // abort overrides everything, including a coincident start
      if (abort)
         state_nxt = S_IDLE;
   end

   always_ff @(posedge io_mainClk or posedge io_systemReset) begin
      if (io_systemReset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // end index is captured so bridge writes mid-run cannot move the target
   always_ff @(posedge io_mainClk or posedge io_systemReset) begin
      if (io_systemReset) begin
         chain_reg <= '0;
         step_reg  <= '0;
         end_reg   <= '0;
         iter_reg  <= '0;
      end else if (accept) begin
         chain_reg <= chain_in;
         step_reg  <= start_step;
         end_reg   <= end_step;
         iter_reg  <= '0;
      end else if (advance) begin
         chain_reg <= hash_digest;
         step_reg  <= step_inc;
         iter_reg  <= iter_reg + 1'b1;
      end
   end

   assign hash_start = (state == S_ISSUE);
   assign busy       = (state == S_ISSUE) || (state == S_WAIT);
   assign done       = (state == S_FIN);
   assign hash_step  = step_reg;
   assign hash_msg   = chain_reg;
   assign chain_out  = chain_reg;
   assign iter_cnt   = iter_reg;

endmodule

// File: tb/tb_gen_chain_seq.sv
`timescale 1ns/1ps
// Bench for gen_chain_seq: hash core model (digest = msg + 1) with a
// scoreboard of expected hash requests pushed when a run is started.
module tb_gen_chain_seq;
   localparam int LW = 4;
   localparam int N  = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [LW-1:0] start_step = '0;
   logic [LW-1:0] end_step = '0;
   logic [N-1:0]  chain_in = '0;
   logic          hash_start;
   logic [LW-1:0] hash_step;
   logic [N-1:0]  hash_msg;
   logic          hash_done = 1'b0;
   logic [N-1:0]  hash_digest = '0;
   logic [N-1:0]  chain_out;
   logic [LW-1:0] iter_cnt;
   logic          busy;
   logic          done;

   int checks = 0;
   int failures = 0;
   int lat = 3;
   int hs_count = 0;
   bit spur = 0;

   logic [LW-1:0] exp_step_q[$];
   logic [N-1:0]  exp_msg_q[$];

   gen_chain_seq dut (
      .io_mainClk     (clk),
      .io_systemReset (rst),
      .start          (start),
      .abort          (abort),
      .start_step     (start_step),
      .end_step       (end_step),
      .chain_in       (chain_in),
      .hash_start     (hash_start),
      .hash_step      (hash_step),
      .hash_msg       (hash_msg),
      .hash_done      (hash_done),
      .hash_digest    (hash_digest),
      .chain_out      (chain_out),
      .iter_cnt       (iter_cnt),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   // hash core model, acting on falling edges
   initial begin : hash_model
      int            cnt;
      logic [N-1:0]  held_msg;
      logic [LW-1:0] held_step;
      logic [LW-1:0] es;
      logic [N-1:0]  em;
      cnt = 0;
      held_msg = '0;
      held_step = '0;
      forever begin
         @(negedge clk);
         hash_done = 1'b0;
         if (rst) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               checks++;
               if (hash_msg !== held_msg || hash_step !== held_step) begin
                  failures++;
                  $display("FAIL hold_stable step=%0d msg=%h required step=%0d msg=%h",
                           hash_step, hash_msg, held_step, held_msg);
               end
               cnt--;
               if (cnt == 0) begin
                  hash_done = 1'b1;
                  hash_digest = held_msg + 1;
               end
            end
            if (hash_start === 1'b1) begin
               hs_count++;
               checks++;
               if (exp_step_q.size() == 0) begin
                  failures++;
                  $display("FAIL hash_issue unexpected step=%0d required none", hash_step);
               end else begin
                  es = exp_step_q.pop_front();
                  em = exp_msg_q.pop_front();
                  if (hash_step !== es || hash_msg !== em) begin
                     failures++;
                     $display("FAIL hash_issue step=%0d msg=%h required step=%0d msg=%h",
                              hash_step, hash_msg, es, em);
                  end
               end
               held_msg = hash_msg;
               held_step = hash_step;
               cnt = (lat < 1) ? 1 : lat;
               if (spur) begin
                  hash_done = 1'b1;
                  hash_digest = 256'hDEAD;
                  spur = 0;
               end
            end
         end
      end
   end

   task automatic drive_start(input logic [LW-1:0] ss, input logic [LW-1:0] es,
                              input logic [N-1:0] cin);
      start_step = ss;
      end_step = es;
      chain_in = cin;
      start = 1'b1;
      for (int s = int'(ss); s < int'(es); s++) begin
         exp_step_q.push_back(LW'(s));
         exp_msg_q.push_back(cin + N'(s - int'(ss)));
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input int bound,
                            output int cyc, output bit ok);
      cyc = cyc0;
      ok = 0;
      while (cyc < cyc0 + bound) begin
         if (done === 1'b1) begin
            ok = 1;
            break;
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({hash_start, busy, done} !== 3'b000 || hash_step !== '0 ||
          hash_msg !== '0 || chain_out !== '0 || iter_cnt !== '0) begin
         failures++;
         $display("FAIL reset_values hs=%b busy=%b done=%b step=%0d iter=%0d chain=%h required all 0",
                  hash_start, busy, done, hash_step, iter_cnt, chain_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int cyc;
      bit ok;
      lat = 3;
      hs_count = 0;
      drive_start(4'd3, 4'd7, 256'h10);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy_rise busy=%b required 1", busy);
      end
      wait_done(1, 100, cyc, ok);
      checks++;
      if (!ok || cyc + 1 != 18) begin
         failures++;
         $display("FAIL basic_latency done=%b cycles=%0d required 18", ok, cyc + 1);
      end
      checks++;
      if (busy !== 1'b0 || chain_out !== 256'h14 || iter_cnt !== 4'd4) begin
         failures++;
         $display("FAIL basic_result busy=%b chain=%h iter=%0d required 0 14 4",
                  busy, chain_out, iter_cnt);
      end
      checks++;
      if (hs_count != 4 || exp_step_q.size() != 0) begin
         failures++;
         $display("FAIL basic_hash_count got=%0d pending=%0d required 4 0",
                  hs_count, exp_step_q.size());
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || chain_out !== 256'h14) begin
         failures++;
         $display("FAIL basic_done_width done=%b chain=%h required 0 14", done, chain_out);
      end
   endtask

   task automatic test_zero_iter(input logic [LW-1:0] ss, input logic [LW-1:0] es,
                                 input logic [N-1:0] cin);
      int cyc;
      bit ok;
      hs_count = 0;
      drive_start(ss, es, cin);
      wait_done(1, 10, cyc, ok);
      checks++;
      if (!ok || cyc + 1 != 2) begin
         failures++;
         $display("FAIL zero_latency %0d->%0d done=%b cycles=%0d required 2", ss, es, ok, cyc + 1);
      end
      checks++;
      if (chain_out !== cin || iter_cnt !== 4'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_result %0d->%0d chain=%h iter=%0d busy=%b required %h 0 0",
                  ss, es, chain_out, iter_cnt, busy, cin);
      end
      @(negedge clk);
      checks++;
      if (hs_count != 0 || done !== 1'b0) begin
         failures++;
         $display("FAIL zero_no_hash hash_starts=%0d done=%b required 0 0", hs_count, done);
      end
   endtask

   task automatic test_ignore();
      int cyc;
      bit ok;
      lat = 3;
      hs_count = 0;
      spur = 1;
      drive_start(4'd3, 4'd7, 256'h10);
      repeat (4) @(negedge clk);
      start_step = 4'd0;
      end_step = 4'd1;
      chain_in = 256'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_step = 4'd3;
      end_step = 4'd7;
      chain_in = 256'h10;
      wait_done(6, 100, cyc, ok);
      checks++;
      if (!ok || cyc + 1 != 18) begin
         failures++;
         $display("FAIL ignore_latency done=%b cycles=%0d required 18", ok, cyc + 1);
      end
      checks++;
      if (chain_out !== 256'h14 || iter_cnt !== 4'd4 || hs_count != 4) begin
         failures++;
         $display("FAIL ignore_result chain=%h iter=%0d hash_starts=%0d required 14 4 4",
                  chain_out, iter_cnt, hs_count);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int cyc;
      bit ok;
      bit saw_done;
      lat = 3;
      hs_count = 0;
      drive_start(4'd3, 4'd7, 256'h10);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || iter_cnt !== 4'd1 || chain_out !== 256'h11) begin
         failures++;
         $display("FAIL abort_state busy=%b done=%b iter=%0d chain=%h required 0 0 1 11",
                  busy, done, iter_cnt, chain_out);
      end
      saw_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL abort_quiet activity after abort required none");
      end
      exp_step_q.delete();
      exp_msg_q.delete();
      hs_count = 0;
      start_step = 4'd0;
      end_step = 4'd4;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hs_count != 0) begin
         failures++;
         $display("FAIL abort_wins busy=%b done=%b hash_starts=%0d required 0 0 0",
                  busy, done, hs_count);
      end
      lat = 2;
      drive_start(4'd0, 4'd2, 256'h100);
      wait_done(1, 100, cyc, ok);
      checks++;
      if (!ok || cyc + 1 != 8 || chain_out !== 256'h102 || iter_cnt !== 4'd2) begin
         failures++;
         $display("FAIL abort_restart done=%b cycles=%0d chain=%h iter=%0d required 8 102 2",
                  ok, cyc + 1, chain_out, iter_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit ok;
      logic [N-1:0] cin;
      lat = 3;
      drive_start(4'd3, 4'd7, 256'h10);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({hash_start, busy, done} !== 3'b000 || hash_step !== '0 ||
          hash_msg !== '0 || chain_out !== '0 || iter_cnt !== '0) begin
         failures++;
         $display("FAIL async_reset hs=%b busy=%b done=%b step=%0d iter=%0d chain=%h required all 0",
                  hash_start, busy, done, hash_step, iter_cnt, chain_out);
      end
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      exp_step_q.delete();
      exp_msg_q.delete();
      @(negedge clk);
      lat = 0;
      hs_count = 0;
      for (int k = 0; k < 8; k++) cin[k*32 +: 32] = $urandom;
      drive_start(4'd0, 4'd15, cin);
      wait_done(1, 200, cyc, ok);
      checks++;
      if (!ok || cyc + 1 != 32) begin
         failures++;
         $display("FAIL full_chain_latency done=%b cycles=%0d required 32", ok, cyc + 1);
      end
      checks++;
      if (chain_out !== cin + 15 || iter_cnt !== 4'd15 || hs_count != 15) begin
         failures++;
         $display("FAIL full_chain_result chain=%h iter=%0d hash_starts=%0d required %h 15 15",
                  chain_out, iter_cnt, hs_count, cin + 15);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_iter(4'd5, 4'd5, 256'hAB);
      test_zero_iter(4'd9, 4'd2, 256'h55);
      test_ignore();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gen_chain_seq.md
Name: gen_chain_seq

Overview:
- WOTS chain sequencer inside the gen-chain datapath, directly downstream of the APB3 register bridge.
- Receives the one-cycle start pulse, the start/end step indices and the 256-bit chain input from the bridge registers.
- Drives a SHA256XMSS-style hash core once per chain step through a start/done handshake, feeding each digest back as the next message.
- Returns the final chain value plus busy/done status to the bridge.

Parameters:
WOTS_W, 16, Winternitz parameter; number of chain positions.
WOTS_LOG_W, CLOG2(WOTS_W), width of step indices.
N, 256, hash and chain value width in bits.

Ports:
io_mainClk  input  1  clock
io_systemReset  input  1  reset; asynchronous, active-high
start  input  1  one-cycle pulse from bridge; begins a chain run
abort  input  1  level/pulse; cancels run, returns to IDLE
start_step  input  WOTS_LOG_W  first step index i
end_step  input  WOTS_LOG_W  exclusive end index
chain_in  input  N  initial chain value
hash_start  output  1  one-cycle request to hash core
hash_step  output  WOTS_LOG_W  current step index; address/bitmask generation
hash_msg  output  N  message for current step
hash_done  input  1  one-cycle completion from hash core
hash_digest  input  N  digest; valid when hash_done=1
chain_out  output  N  current/final chain value
iter_cnt  output  WOTS_LOG_W  hash calls completed in current run
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at run completion

Behaviour:
- Reset values: all outputs 0; state IDLE; chain_reg, step_reg and iter_cnt cleared. Reset mid-run drops the run immediately; no done pulse.
- States: IDLE, ISSUE, WAIT, FIN. All outputs are registered or decoded from state.
- IDLE:
  - start=1 latches chain_reg<=chain_in, step_reg<=start_step, iter_cnt<=0.
  - If end_step>start_step, go to ISSUE; else go to FIN (zero iterations, chain_out=chain_in).
  - busy rises in the cycle after start.
- ISSUE: hash_start=1 for exactly this cycle, with hash_step=step_reg and hash_msg=chain_reg. Next state WAIT.
- WAIT:
  - Hold until hash_done=1.
  - On hash_done: chain_reg<=hash_digest, step_reg<=step_reg+1, iter_cnt<=iter_cnt+1.
  - If step_reg+1==end_step, go to FIN; else go to ISSUE.
- FIN: done=1 for one cycle, busy=0 in this cycle, chain_out holds the final value. Next state IDLE.
- Per-step cost: 1 (ISSUE) + hash latency (cycles until hash_done in WAIT) + 0. Total run: 1 + Σ(1+Lhash) + 1 cycles from start to done.
- start while not in IDLE: ignored, no effect on any register.
- hash_done outside WAIT, including the ISSUE cycle: ignored. The hash core must take ≥1 cycle.
- abort: any state goes to IDLE next cycle, busy=0, no done pulse; chain_out keeps its last value. If start and abort are both high in the same cycle, abort wins.
- Width rules:
  - end_step ≤ WOTS_W-1 is guaranteed by software, so step_reg+1 never wraps.
  - If end_step<start_step, the run is treated as zero iterations (FIN path).
- chain_out=chain_reg continuously; it is stable and valid whenever busy=0 after the first done.
- hash_msg and hash_step hold stable from ISSUE through WAIT until hash_done.

Test Plan:
- Model digest=msg+1 with Lhash=3. Stimulus: start_step=3, end_step=7, chain_in=0x10. Required: 4 hash_start pulses with hash_step=3,4,5,6; chain_out=0x14; iter_cnt=4; done 1 cycle; start-to-done = 1+4×4+1 = 18 cycles.
- start_step=5, end_step=5, chain_in=0xAB. Required: no hash_start; done 2 cycles after start; chain_out=0xAB; iter_cnt=0.
- start_step=9, end_step=2. Required: zero-iteration path, same as the previous case; no hash_start.
- Second start pulse issued mid-run and a spurious hash_done during ISSUE. Required: both ignored; final result identical to the first scenario.
- abort asserted during the second WAIT of the 3→7 run. Required: IDLE next cycle, busy=0, no done, iter_cnt=1. A new start then completes normally.
- io_systemReset asserted mid-WAIT. Required: all outputs 0 asynchronously; after release, a start with 0→15 and Lhash=0 produces 15 hashes and chain_out=chain_in+15.
